keypad_encoder: RTL and testbench
=================================

# keypad_encoder

Converts the 16 raw ATM keypad lines into a debounced 4-bit key code with a valid/ready handshake. It is the inverse of the 4-to-16 one-hot select decoder: that decoder expands a 4-bit code (A = MSB, D = LSB) to `sel_out[15:0]`, and this block collapses `key_in[15:0]` back to that code. It sits between the physical keypad and the ATM control FSM. Each clean press produces exactly one code transfer, and a new press is accepted only after a debounced release.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive identical synchronized samples required to accept a press or a release; legal range 2..65535.
- `clk` in 1: single clock; all state on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `key_in` in 16: raw key lines, asynchronous; bit i high = key i pressed.
- `key_ready` in 1: consumer ready.
- `key_code` out 4: encoded key, i.e. the index of the single high bit.
- `key_valid` out 1: `key_code` is offered.
- `key_busy` out 1: high whenever the FSM is not IDLE.

## Operation
- `key_in` passes through a two-flop synchronizer, giving `s2`. All decisions use `s2` only.
- A "legal press" is `s2` exactly one-hot. Zero or multiple bits set is never a legal press.
- FSM states and transitions:
  - IDLE:
    - If `s2` is one-hot: capture `key_code` = index, capture the pattern, set `cnt` = 1, go to DEB_PRESS.
    - Otherwise stay in IDLE.
  - DEB_PRESS:
    - If `s2` equals the captured pattern and `cnt` == DEBOUNCE_CYCLES-1: go to PRESENT.
    - Else if `s2` equals the captured pattern: `cnt`++.
    - Else (any mismatch, including a second key) go to IDLE. `key_code` keeps its value; no output.
  - PRESENT:
    - `key_valid` = 1.
    - On `key_valid` & `key_ready`, go to WAIT_REL.
    - Changes on `s2` are ignored and `key_code` is frozen.
  - WAIT_REL: if `s2` == 0, set `cnt` = 1 and go to DEB_REL.
  - DEB_REL:
    - If `s2` != 0: go to WAIT_REL.
    - Else if `cnt` == DEBOUNCE_CYCLES-1: go to IDLE.
    - Else `cnt`++.
- Output derivations:
  - `key_valid` = (state == PRESENT), registered state decode.
  - `key_busy` = (state != IDLE).
  - `key_code` is updated only on the IDLE capture.
- `cnt` width = clog2(DEBOUNCE_CYCLES). `cnt` never wraps; it stops at DEBOUNCE_CYCLES-1.

## Timing
- Reset: state = IDLE; `cnt`, synchronizer flops, `key_code` = 0; `key_valid` = 0; `key_busy` = 0. Applies from the edge where `rst` is sampled high, including mid-debounce and mid-handshake; any pending key is discarded.
- Press latency: with `key_in` one-hot and stable before edge 0:
  - the synchronizer is full after edge 1;
  - the IDLE capture happens at edge 2;
  - `key_valid` rises after edge DEBOUNCE_CYCLES+1.
- Handshake:
  - `key_valid` holds and `key_code` is stable until the transfer edge (`key_valid` & `key_ready` sampled high); `key_valid` falls after that edge.
  - Transfer requires `key_valid` high; `key_ready` held high early has no effect.
  - `key_ready` high before PRESENT gives a transfer on the first PRESENT cycle.
- Release: after the transfer, `s2` must read zero for DEBOUNCE_CYCLES consecutive samples before IDLE. A nonzero sample restarts the release count.
- A key held through the whole transfer produces no second code; that key needs a debounced release before it can be reported again.
- Press glitch shorter than DEBOUNCE_CYCLES samples: no `key_valid`; return to IDLE and rearm immediately.

## Structure
- Package `keypad_pkg`:
  - state enum `kp_state_t` {IDLE, DEB_PRESS, PRESENT, WAIT_REL, DEB_REL};
  - function `onehot16_to_code` (index of the high bit);
  - function `is_onehot16`.
- Sub-module `keypad_sync`: 2-flop, 16-bit synchronizer with synchronous reset to 0.
- The top holds the FSM, the debounce counter and the output registers.

## Test plan
(All scenarios use DEBOUNCE_CYCLES = 4.)
- Reset: `rst` high for 2 cycles, `key_in` = 16'h0020 -> `key_valid` = 0, `key_busy` = 0, `key_code` = 0 throughout reset; after `rst` falls, `key_valid` rises after edge 5 counted from the first post-reset edge.
- Clean press: `key_in` = 16'h0200 from before edge 0, `key_ready` = 1 -> `key_valid` rises after edge 5 with `key_code` = 9 and stays high exactly one cycle. Then `key_in` = 0 -> `key_busy` falls after 4 zero samples plus 2 synchronizer cycles.
- Backpressure: `key_in` = 16'h8000 held, `key_ready` = 0 for 10 cycles, then 1 -> `key_valid` and `key_code` = 15 stable for all 10 cycles; exactly one transfer; no second `key_valid` while the key stays held.
- Bounce: `key_in` = 16'h0004 for 2 cycles, 0 for 1 cycle, 16'h0004 for 2 cycles, then 0 -> `key_valid` never asserts; state returns to IDLE.
- Multi-key: `key_in` = 16'h0003 held for 20 cycles -> no `key_valid`, `key_busy` = 0. Then change to 16'h0002 -> `key_code` = 1 transferred.
- Release bounce: after a transfer of key 7, `key_in` goes 0,0,0,16'h0080,0,0,0,0 -> IDLE is reached only after the final 4 zero samples. A new press of key 0 is then reported with `key_code` = 0.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad encoder: FSM state encoding and
// one-hot helpers for the 16 keypad lines.
package keypad_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        DEB_PRESS = 3'd1,
        PRESENT   = 3'd2,
        WAIT_REL  = 3'd3,
        DEB_REL   = 3'd4
    } kp_state_t;

    // Index of the highest set bit; callers only pass exact one-hot patterns.
    function automatic logic [3:0] onehot16_to_code(input logic [15:0] v);
        logic [3:0] code;
        code = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (v[i]) begin
                code = 4'(i);
            end
        end
        return code;
    endfunction

    function automatic logic is_onehot16(input logic [15:0] v);
        return (v != '0) && ((v & (v - 16'd1)) == '0);
    endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchronizer for the 16 asynchronous keypad lines,
// synchronous active-high reset to zero.
module keypad_sync
    import keypad_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] i_d,
    output logic [15:0] o_q
);

    logic [15:0] r_s1;
    logic [15:0] r_s2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
        end
    end

    assign o_q = r_s2;

endmodule

// File: rtl/keypad_encoder.sv
// Debounced 16-line keypad to 4-bit code encoder with valid/ready handshake;
// one transfer per clean press, re-armed only after a debounced release.
module keypad_encoder
    import keypad_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] key_in,
    input  logic        key_ready,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic        key_busy
);

    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [15:0] w_s2;
    logic        w_onehot;
    logic [3:0]  w_code;

    kp_state_t   r_state;
    logic [CW-1:0] r_cnt;
    logic [15:0] r_pattern;
    logic [3:0]  r_code;

    keypad_sync u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (key_in),
        .o_q (w_s2)
    );

    assign w_onehot = is_onehot16(w_s2);
    assign w_code   = onehot16_to_code(w_s2);

    // Counter starts at 1 on entry because the entry sample already counts.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_pattern <= '0;
            r_code    <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_onehot) begin
                        r_code    <= w_code;
                        r_pattern <= w_s2;
                        r_cnt     <= CW'(1);
                        r_state   <= DEB_PRESS;
                    end
                end
                DEB_PRESS: begin
                    if (w_s2 != r_pattern) begin
                        r_state <= IDLE;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= PRESENT;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                PRESENT: begin
                    if (key_ready) begin
                        r_state <= WAIT_REL;
                    end
                end
                WAIT_REL: begin
                    if (w_s2 == '0) begin
                        r_cnt   <= CW'(1);
                        r_state <= DEB_REL;
                    end
                end
                DEB_REL: begin
                    if (w_s2 != '0) begin
                        r_state <= WAIT_REL;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign key_valid = (r_state == PRESENT);
    assign key_busy  = (r_state != IDLE);
    assign key_code  = r_code;

endmodule

// File: tb/tb_keypad_encoder.sv
// Directed bench for keypad_encoder with DEBOUNCE_CYCLES = 4; expected values
// are hand-derived cycle counts from the synchronizer and debounce timing.
module tb_keypad_encoder;

    logic        clk;
    logic        rst;
    logic [15:0] key_in;
    logic        key_ready;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_busy;

    int checks;
    int errors;

    keypad_encoder #(.DEBOUNCE_CYCLES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .key_in    (key_in),
        .key_ready (key_ready),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_busy  (key_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // From WAIT_REL with the key still visible: drop key_in; busy must stay
    // high for 5 edges (2 sync + 3 zero samples) and fall on the 6th.
    task automatic release_check(input string tag);
        key_in = '0;
        for (int i = 0; i < 5; i++) tick();
        check({tag, "_busy_hold"}, 16'(key_busy), 16'd1);
        tick();
        check({tag, "_busy_fall"}, 16'(key_busy), 16'd0);
    endtask

    // From IDLE with s2 clear: set key, valid low after 5 edges, high after 6th.
    task automatic press_check(input string tag, input logic [15:0] key, input logic [3:0] code);
        key_in = key;
        for (int i = 0; i < 5; i++) tick();
        check({tag, "_valid_early"}, 16'(key_valid), 16'd0);
        tick();
        check({tag, "_valid_rise"}, 16'(key_valid), 16'd1);
        check({tag, "_code"}, 16'(key_code), 16'(code));
    endtask

    logic       saw_valid;
    logic       saw_busy;
    logic [15:0] seq_key [10];
    logic       seq_busy [10];

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        key_in    = 16'h0020;
        key_ready = 1'b1;

        // Reset held two cycles with a key present.
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_valid", 16'(key_valid), 16'd0);
            check("rst_busy",  16'(key_busy),  16'd0);
            check("rst_code",  16'(key_code),  16'd0);
        end
        rst = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("post_rst_valid_early", 16'(key_valid), 16'd0);
        tick();
        check("post_rst_valid_rise", 16'(key_valid), 16'd1);
        check("post_rst_code", 16'(key_code), 16'd5);
        tick();
        check("post_rst_xfer", 16'(key_valid), 16'd0);
        release_check("post_rst_rel");

        // Clean press, ready held high early: one-cycle valid.
        key_ready = 1'b1;
        press_check("clean", 16'h0200, 4'd9);
        tick();
        check("clean_valid_one_cycle", 16'(key_valid), 16'd0);
        check("clean_busy_wait_rel", 16'(key_busy), 16'd1);
        release_check("clean_rel");

        // Backpressure: ready low for 10 valid cycles.
        key_ready = 1'b0;
        press_check("bp", 16'h8000, 4'd15);
        for (int i = 0; i < 9; i++) begin
            tick();
            check("bp_hold_valid", 16'(key_valid), 16'd1);
            check("bp_hold_code",  16'(key_code),  16'd15);
        end
        key_ready = 1'b1;
        tick();
        check("bp_xfer", 16'(key_valid), 16'd0);
        saw_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (key_valid) saw_valid = 1'b1;
        end
        check("bp_no_second_valid", 16'(saw_valid), 16'd0);
        check("bp_held_busy", 16'(key_busy), 16'd1);
        release_check("bp_rel");

        // Press bounce shorter than the debounce window.
        saw_valid = 1'b0;
        key_in = 16'h0004; tick(); if (key_valid) saw_valid = 1'b1;
        tick(); if (key_valid) saw_valid = 1'b1;
        key_in = 16'h0000; tick(); if (key_valid) saw_valid = 1'b1;
        key_in = 16'h0004; tick(); if (key_valid) saw_valid = 1'b1;
        tick(); if (key_valid) saw_valid = 1'b1;
        key_in = 16'h0000;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (key_valid) saw_valid = 1'b1;
        end
        check("bounce_no_valid", 16'(saw_valid), 16'd0);
        check("bounce_idle", 16'(key_busy), 16'd0);
        check("bounce_code_captured", 16'(key_code), 16'd2);

        // Two keys at once are never a legal press.
        saw_valid = 1'b0;
        saw_busy  = 1'b0;
        key_in = 16'h0003;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (key_valid) saw_valid = 1'b1;
            if (key_busy)  saw_busy  = 1'b1;
        end
        check("multi_no_valid", 16'(saw_valid), 16'd0);
        check("multi_no_busy",  16'(saw_busy),  16'd0);
        press_check("multi_then_single", 16'h0002, 4'd1);
        tick();
        check("multi_xfer", 16'(key_valid), 16'd0);
        release_check("multi_rel");

        // Release bounce: the 0x0080 sample restarts the zero count.
        press_check("relb", 16'h0080, 4'd7);
        tick();
        check("relb_xfer", 16'(key_valid), 16'd0);
        seq_key = '{16'h0000, 16'h0000, 16'h0000, 16'h0080, 16'h0000,
                    16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        seq_busy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                     1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 10; k++) begin
            key_in = seq_key[k];
            tick();
            check($sformatf("relb_busy_e%0d", k), 16'(key_busy), 16'(seq_busy[k]));
        end
        press_check("relb_key0", 16'h0001, 4'd0);
        tick();
        check("relb_key0_xfer", 16'(key_valid), 16'd0);
        release_check("relb_key0_rel");

        // Reset in the middle of a pending handshake discards the key.
        key_ready = 1'b0;
        press_check("midrst", 16'h0010, 4'd4);
        rst = 1'b1;
        tick();
        check("midrst_valid", 16'(key_valid), 16'd0);
        check("midrst_busy",  16'(key_busy),  16'd0);
        check("midrst_code",  16'(key_code),  16'd0);
        rst    = 1'b0;
        key_in = '0;
        saw_busy = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (key_busy) saw_busy = 1'b1;
        end
        check("midrst_stays_idle", 16'(saw_busy), 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
